// File: rtl/pipeline_stall_pkg.sv
// pipeline_stall_pkg: controller state encoding and sequence-count width
package pipeline_stall_pkg;
   typedef enum logic [2:0] {RUN, LU_STALL, FLUSH, MEM_WAIT, HALT} stall_state_t;
   localparam int SEQ_W = 4;
endpackage

// File: rtl/stall_perf_counter.sv
// stall_perf_counter: saturating event counter, clears on reset
module stall_perf_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] cnt
);
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) cnt <= '0;
      else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: Mealy stall/flush/bubble sequencer for the 5-stage core.
// Perf counters are built only when STALL_PERF_CNT_EN is defined; otherwise they read 0.
module pipeline_stall_ctrl
   import pipeline_stall_pkg::*;
#(
   parameter int FLUSH_CYCLES    = 2,
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 i_load_use,
   input  logic                 i_redirect,
   input  logic                 i_mem_busy,
   input  logic                 i_halt,
   output logic                 o_pc_we,
   output logic                 o_ifid_we,
   output logic                 o_ifid_flush,
   output logic                 o_idex_bubble,
   output logic                 o_back_we,
   output logic                 o_halted,
   output logic [CNT_WIDTH-1:0] o_lu_cnt,
   output logic [CNT_WIDTH-1:0] o_flush_cnt,
   output logic [CNT_WIDTH-1:0] o_memwait_cnt
);
   stall_state_t state, state_nx, saved, saved_nx, eff;
   logic [SEQ_W-1:0] cnt, cnt_nx;

   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
         state <= RUN;
         saved <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         saved <= saved_nx;
         cnt   <= cnt_nx;
      end

   // MEM_WAIT behaves as the frozen state on the cycle busy drops, so resuming adds no latency
   always_comb begin
      eff           = (state == MEM_WAIT) ? saved : state;
      state_nx      = eff;
      saved_nx      = saved;
      cnt_nx        = cnt;
      o_pc_we       = 1'b1;
      o_ifid_we     = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_bubble = 1'b0;
      o_back_we     = 1'b1;
      o_halted      = 1'b0;
      if (state == HALT || i_halt) begin
         state_nx  = HALT;
         o_pc_we   = 1'b0;
         o_ifid_we = 1'b0;
         o_back_we = 1'b0;
         o_halted  = 1'b1;
      end else if (i_mem_busy) begin
         state_nx  = MEM_WAIT;
         saved_nx  = eff;
         o_pc_we   = 1'b0;
         o_ifid_we = 1'b0;
         o_back_we = 1'b0;
      end else if (i_redirect) begin
         o_ifid_flush  = 1'b1;
         o_idex_bubble = 1'b1;
         cnt_nx        = SEQ_W'(FLUSH_CYCLES - 1);
         state_nx      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (eff == FLUSH) begin
         o_ifid_flush = 1'b1;
         cnt_nx       = cnt - SEQ_W'(1);
         state_nx     = (cnt == SEQ_W'(1)) ? RUN : FLUSH;
      end else if (eff == LU_STALL || i_load_use) begin
         o_pc_we       = 1'b0;
         o_ifid_we     = 1'b0;
         o_idex_bubble = 1'b1;
         cnt_nx        = (eff == LU_STALL) ? cnt - SEQ_W'(1) : SEQ_W'(LU_STALL_CYCLES - 1);
         state_nx      = (eff == LU_STALL) ? ((cnt == SEQ_W'(1)) ? RUN : LU_STALL)
                                           : ((LU_STALL_CYCLES > 1) ? LU_STALL : RUN);
      end
   end

`ifdef STALL_PERF_CNT_EN
   // a bubble without a flush can only come from a load-use stall
   stall_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lu_cnt (
      .CLK(CLK), .RSTn(RSTn), .en(o_idex_bubble && !o_ifid_flush), .cnt(o_lu_cnt)
   );
   stall_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .CLK(CLK), .RSTn(RSTn), .en(o_ifid_flush), .cnt(o_flush_cnt)
   );
   stall_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_memwait_cnt (
      .CLK(CLK), .RSTn(RSTn), .en(i_mem_busy && !o_halted), .cnt(o_memwait_cnt)
   );
`else
   assign o_lu_cnt      = '0;
   assign o_flush_cnt   = '0;
   assign o_memwait_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: two configurations against a remaining-cycle reference model
module tb_pipeline_stall_ctrl;
`ifdef STALL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic CLK = 1'b0, RSTn = 1'b0;
   logic load_use = 1'b0, redirect = 1'b0, mem_busy = 1'b0, halt = 1'b0;
   logic pc_we[2], ifid_we[2], flush[2], bubble[2], back_we[2], halted[2];
   logic [3:0] lu_cnt[2], fl_cnt[2], mw_cnt[2];
   logic [17:0] obs[2], exp_v[2];
   int total = 0, passed = 0;

   typedef struct {int lu_rem; int fl_rem; bit hlt; int lc; int fc; int mc;} model_t;
   model_t m[2], m_nx[2];
   int fcyc[2] = '{2, 3};
   int lcyc[2] = '{1, 3};

   always #5 CLK = ~CLK;

   pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .LU_STALL_CYCLES(1), .CNT_WIDTH(4)) dut_a (
      .CLK(CLK), .RSTn(RSTn), .i_load_use(load_use), .i_redirect(redirect),
      .i_mem_busy(mem_busy), .i_halt(halt), .o_pc_we(pc_we[0]), .o_ifid_we(ifid_we[0]),
      .o_ifid_flush(flush[0]), .o_idex_bubble(bubble[0]), .o_back_we(back_we[0]),
      .o_halted(halted[0]), .o_lu_cnt(lu_cnt[0]), .o_flush_cnt(fl_cnt[0]), .o_memwait_cnt(mw_cnt[0])
   );
   pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .LU_STALL_CYCLES(3), .CNT_WIDTH(4)) dut_b (
      .CLK(CLK), .RSTn(RSTn), .i_load_use(load_use), .i_redirect(redirect),
      .i_mem_busy(mem_busy), .i_halt(halt), .o_pc_we(pc_we[1]), .o_ifid_we(ifid_we[1]),
      .o_ifid_flush(flush[1]), .o_idex_bubble(bubble[1]), .o_back_we(back_we[1]),
      .o_halted(halted[1]), .o_lu_cnt(lu_cnt[1]), .o_flush_cnt(fl_cnt[1]), .o_memwait_cnt(mw_cnt[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_obs
      assign obs[g] = {pc_we[g], ifid_we[g], flush[g], bubble[g], back_we[g], halted[g],
                       lu_cnt[g], fl_cnt[g], mw_cnt[g]};
   end

   function automatic logic [3:0] sat(int x);
      return PERF ? ((x > 15) ? 4'd15 : 4'(x)) : 4'd0;
   endfunction

   // control vector order: pc_we, ifid_we, ifid_flush, idex_bubble, back_we, halted
   function automatic void eval(int k, logic [3:0] v);
      model_t s = m[k];
      logic [5:0] c;
      logic [11:0] cn = {sat(s.lc), sat(s.fc), sat(s.mc)};
      if (s.hlt || v[0]) begin c = 6'b000001; s.hlt = 1'b1; end
      else if (v[1]) begin c = 6'b000000; s.mc++; end
      else if (v[2]) begin c = 6'b111110; s.fl_rem = fcyc[k] - 1; s.lu_rem = 0; s.fc++; end
      else if (s.fl_rem > 0) begin c = 6'b111010; s.fl_rem--; s.fc++; end
      else if (v[3] || s.lu_rem > 0) begin
         c = 6'b000110;
         s.lu_rem = (s.lu_rem > 0) ? s.lu_rem - 1 : lcyc[k] - 1;
         s.lc++;
      end else c = 6'b110010;
      exp_v[k] = {c, cn};
      m_nx[k] = s;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m[k] = '{0, 0, 1'b0, 0, 0, 0};
         m_nx[k] = m[k];
      end
   endfunction

   // v = {load_use, redirect, mem_busy, halt}
   task automatic apply(input logic [3:0] v);
      @(negedge CLK);
      m = m_nx;
      {load_use, redirect, mem_busy, halt} = v;
      #1;
      eval(0, v);
      eval(1, v);
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      {load_use, redirect, mem_busy, halt} = 4'b0;
      model_reset();
      #1;
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== {6'b110010, 12'd0})
            $display("FAIL reset dut%0d got %b want %b", k, obs[k], {6'b110010, 12'd0});
         else passed++;
      end
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_load_use();
      logic [3:0] seq[5] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL load_use dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_redirect();
      logic [3:0] seq[5] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL redirect dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_flush_memwait();
      logic [3:0] seq[8] = '{4'b0100, 4'b0010, 4'b0110, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL flush_memwait dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_redirect_load_use();
      logic [3:0] seq[4] = '{4'b1100, 4'b1000, 4'b1000, 4'b0000};
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL redirect_load_use dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq[12] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0000,
                              4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL back_to_back dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         apply({$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, 1'b0});
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL random dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 21; i++) begin
         apply((i < 20) ? 4'b1000 : 4'b0000);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL saturation dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
      total++;
      if (lu_cnt[0] !== (PERF ? 4'd15 : 4'd0)) $display("FAIL lu_cnt_sat got %0d want %0d", lu_cnt[0], PERF ? 15 : 0);
      else passed++;
   endtask

   task automatic test_halt();
      logic [3:0] seq[4] = '{4'b0011, 4'b0000, 4'b1100, 4'b0010};
      do_reset();
      apply(4'b0100);
      foreach (seq[i]) begin
         apply(seq[i]);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) $display("FAIL halt dut%0d cyc%0d got %b want %b", k, i, obs[k], exp_v[k]);
            else passed++;
         end
      end
      #1;
      {load_use, redirect, mem_busy, halt} = 4'b0;
      RSTn = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== {6'b110010, 12'd0}) $display("FAIL halt_reset dut%0d got %b want %b", k, obs[k], {6'b110010, 12'd0});
         else passed++;
      end
      @(negedge CLK);
      RSTn = 1'b1;
      apply(4'b0000);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== exp_v[k]) $display("FAIL after_reset dut%0d got %b want %b", k, obs[k], exp_v[k]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_flush_memwait();
      test_redirect_load_use();
      test_back_to_back();
      test_random();
      test_saturation();
      test_halt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
